// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down modulo counter with prescaler, load and sticky flags
module updown_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [15:0]      PC_LAST = 16'(PRESCALE - 1);

    logic [WIDTH-1:0] r_out;
    logic [15:0]      r_pc;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_load_clamped;
    logic             w_pc_last;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    assign w_pc_last      = (r_pc == PC_LAST);
    assign w_at_max       = (r_out == MAX_V);
    assign w_at_zero      = (r_out == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
            r_pc  <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            // Clear first so a boundary event later in this block overrides it
            if (clr_flags) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (load) begin
                r_out <= w_load_clamped;
                r_pc  <= '0;
            end else if (en) begin
                if (w_pc_last) begin
                    r_pc <= '0;
                    if (up) begin
                        if (w_at_max) begin
                            r_out <= (SATURATE != 0) ? MAX_V : '0;
                            r_tc  <= 1'b1;
                            r_ovf <= 1'b1;
                        end else begin
                            r_out <= r_out + 1'b1;
                        end
                    end else begin
                        if (w_at_zero) begin
                            r_out <= (SATURATE != 0) ? '0 : MAX_V;
                            r_tc  <= 1'b1;
                            r_unf <= 1'b1;
                        end else begin
                            r_out <= r_out - 1'b1;
                        end
                    end
                end else begin
                    r_pc <= r_pc + 16'd1;
                end
            end
        end
    end

    assign out = r_out;
    assign tc  = r_tc;
    assign ovf = r_ovf;
    assign unf = r_unf;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - directed self-checking bench for updown_counter_mod
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       clr_flags;

    logic [3:0] out0, out1, out2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;
    logic       unf0, unf1, unf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0: defaults; u1: MAX=9, PRESCALE=3; u2: MAX=5, saturating
    updown_counter_mod u0 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(out0), .tc(tc0), .ovf(ovf0), .unf(unf0)
    );

    updown_counter_mod #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(0)) u1 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(out1), .tc(tc1), .ovf(ovf1), .unf(unf1)
    );

    updown_counter_mod #(.WIDTH(4), .MAX(5), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(out2), .tc(tc2), .ovf(ovf2), .unf(unf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_flags = 1'b0;
        #2;
        chk("rst_out0", 32'(out0), 0);
        chk("rst_tc0", 32'(tc0), 0);
        chk("rst_ovf0", 32'(ovf0), 0);
        chk("rst_unf1", 32'(unf1), 0);
        #18;

        // Test 1: free-running up count with wrap on the default instance
        rstn = 1'b1; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t1_out", 32'(out0), 32'(k % 16));
            chk("t1_tc", 32'(tc0), 32'(k == 16));
            chk("t1_ovf", 32'(ovf0), 32'(k >= 16));
        end

        // Test 2: prescaled down count wraps 0 -> 9 -> 8
        en = 1'b0;
        pulse_reset();
        en = 1'b1; up = 1'b0;
        begin
            logic [3:0] exp_out [6];
            logic       exp_tc  [6];
            logic       exp_unf [6];
            exp_out = '{4'd0, 4'd0, 4'd9, 4'd9, 4'd9, 4'd8};
            exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            exp_unf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int k = 0; k < 6; k++) begin
                tick();
                chk("t2_out", 32'(out1), 32'(exp_out[k]));
                chk("t2_tc", 32'(tc1), 32'(exp_tc[k]));
                chk("t2_unf", 32'(unf1), 32'(exp_unf[k]));
            end
        end

        // Test 4: load clamps, beats a due step, resets pc, clears flags with clr_flags
        tick();
        tick();
        chk("t4_pre_out", 32'(out1), 8);
        load = 1'b1; load_val = 4'd12; clr_flags = 1'b1;
        tick();
        chk("t4_load_out", 32'(out1), 9);
        chk("t4_load_tc", 32'(tc1), 0);
        chk("t4_load_unf", 32'(unf1), 0);
        load = 1'b0; clr_flags = 1'b0; up = 1'b1;
        tick();
        tick();
        chk("t4_pc_hold", 32'(out1), 9);
        tick();
        chk("t4_wrap_out", 32'(out1), 0);
        chk("t4_wrap_tc", 32'(tc1), 1);
        chk("t4_wrap_ovf", 32'(ovf1), 1);

        // Test 5: asynchronous reset mid-count at out=7, pc=1
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("t5_pre_out", 32'(out1), 7);
        #2 rstn = 1'b0;
        #1;
        chk("t5_async_out", 32'(out1), 0);
        chk("t5_async_ovf", 32'(ovf1), 0);
        #2 rstn = 1'b1;
        tick();
        tick();
        chk("t5_resume_hold", 32'(out1), 0);
        tick();
        chk("t5_resume_step", 32'(out1), 1);

        // Test 3: saturating instance re-pulses tc at the bound
        en = 1'b0;
        pulse_reset();
        load = 1'b1; load_val = 4'd4;
        tick();
        chk("t3_load_out", 32'(out2), 4);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_out", 32'(out2), 5);
            chk("t3_tc", 32'(tc2), 32'(k > 0));
            chk("t3_ovf", 32'(ovf2), 32'(k > 0));
        end

        // Test 6: boundary event beats clr_flags; clr_flags alone clears
        en = 1'b0;
        pulse_reset();
        load = 1'b1; load_val = 4'd15;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; clr_flags = 1'b1;
        tick();
        chk("t6_wrap_out", 32'(out0), 0);
        chk("t6_wrap_tc", 32'(tc0), 1);
        chk("t6_wrap_ovf", 32'(ovf0), 1);
        en = 1'b0;
        tick();
        chk("t6_clr_ovf", 32'(ovf0), 0);
        chk("t6_clr_tc", 32'(tc0), 0);
        clr_flags = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
